// File: rtl/float_point_multiplier_stream.sv
// Multi-lane FP multiplier stream: a bundle of operand pairs is held for MULT_LATENCY cycles,
// then the products and per-lane class flags are pushed into a small result FIFO.

// Combinational multiplier core, round-to-nearest-even; denormal operands and underflowing results give signed zero.
module float_point_multiplier #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23
) (
  input  logic [EXP_LEN+MANTISSA_LEN:0] a_i,
  input  logic [EXP_LEN+MANTISSA_LEN:0] b_i,
  output logic [EXP_LEN+MANTISSA_LEN:0] product_o
);
  localparam int SW = MANTISSA_LEN + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_LEN + 2;
  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_LEN - 1)) - 1);
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_LEN) - 1);

  logic                    sign;
  logic [EXP_LEN-1:0]      ea, eb;
  logic [MANTISSA_LEN-1:0] ma, mb, frac;
  logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_den, b_den;
  logic [PW-1:0]           prod;
  logic                    guard, sticky, round_up;
  logic [MANTISSA_LEN:0]   frac_r;
  logic [XW-1:0]           exp_r;

  always_comb begin
    sign   = a_i[EXP_LEN+MANTISSA_LEN] ^ b_i[EXP_LEN+MANTISSA_LEN];
    ea     = a_i[MANTISSA_LEN +: EXP_LEN];
    eb     = b_i[MANTISSA_LEN +: EXP_LEN];
    ma     = a_i[MANTISSA_LEN-1:0];
    mb     = b_i[MANTISSA_LEN-1:0];
    a_nan  = (&ea) && (ma != '0);
    b_nan  = (&eb) && (mb != '0);
    a_inf  = (&ea) && (ma == '0);
    b_inf  = (&eb) && (mb == '0);
    a_zero = (ea == '0) && (ma == '0);
    b_zero = (eb == '0) && (mb == '0);
    a_den  = (ea == '0) && (ma != '0);
    b_den  = (eb == '0) && (mb != '0);

    prod = PW'({1'b1, ma}) * PW'({1'b1, mb});
    // Product of two [1,2) significands lies in [1,4); the top bit selects the normalisation shift.
    if (prod[PW-1]) begin
      frac   = prod[PW-2 -: MANTISSA_LEN];
      guard  = prod[MANTISSA_LEN];
      sticky = |prod[MANTISSA_LEN-1:0];
    end else begin
      frac   = prod[PW-3 -: MANTISSA_LEN];
      guard  = prod[MANTISSA_LEN-1];
      sticky = |prod[MANTISSA_LEN-2:0];
    end
    round_up = guard & (sticky | frac[0]);
    frac_r   = {1'b0, frac} + SW'(round_up);
    exp_r    = {2'b00, ea} + {2'b00, eb} - BIAS + XW'(prod[PW-1]) + XW'(frac_r[MANTISSA_LEN]);

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      product_o = {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};
    else if (a_inf || b_inf)
      product_o = {sign, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
    else if (a_zero || b_zero || a_den || b_den || exp_r[XW-1] || (exp_r == '0))
      product_o = {sign, {(EXP_LEN+MANTISSA_LEN){1'b0}}};
    else if (exp_r >= EMAX)
      product_o = {sign, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
    else
      product_o = {sign, exp_r[EXP_LEN-1:0], frac_r[MANTISSA_LEN-1:0]};
  end
endmodule

module float_point_multiplier_stream #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int NUM_LANES    = 1,
  parameter int MULT_LATENCY = 4,
  parameter int RESULT_DEPTH = 2
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          inp_valid,
  output logic                                          inp_ready,
  input  logic [NUM_LANES*(EXP_LEN+MANTISSA_LEN+1)-1:0] inp_a,
  input  logic [NUM_LANES*(EXP_LEN+MANTISSA_LEN+1)-1:0] inp_b,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_LANES*(EXP_LEN+MANTISSA_LEN+1)-1:0] out_product,
  output logic [NUM_LANES-1:0]                          out_nan_flag,
  output logic [NUM_LANES-1:0]                          out_inf_flag,
  output logic [NUM_LANES-1:0]                          out_zero_flag,
  output logic                                          busy
);
  localparam int W    = EXP_LEN + MANTISSA_LEN + 1;
  localparam int DW   = NUM_LANES * W;
  localparam int EW   = DW + 3 * NUM_LANES;
  localparam int CW   = $clog2(MULT_LATENCY + 1);
  localparam int PTRW = $clog2(RESULT_DEPTH);
  localparam logic [PTRW:0] DEPTH_C = (PTRW+1)'(RESULT_DEPTH);

  typedef enum logic {S_IDLE, S_COMPUTE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]          opa_q, opa_d, opb_q, opb_d, core_prod;
  logic [NUM_LANES-1:0]   nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
  logic [NUM_LANES-1:0]   nan_c, inf_c, zero_c;
  logic [PTRW-1:0]        rd_q, wr_q;
  logic [PTRW:0]          count_q;
  logic [EW-1:0]          mem_q [RESULT_DEPTH];
  logic                   accept, push, pop;

  function automatic logic [2:0] classify(input logic [W-1:0] a, input logic [W-1:0] b);
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, nan, inf;
    a_nan  = (&a[MANTISSA_LEN +: EXP_LEN]) && (a[MANTISSA_LEN-1:0] != '0);
    b_nan  = (&b[MANTISSA_LEN +: EXP_LEN]) && (b[MANTISSA_LEN-1:0] != '0);
    a_inf  = (&a[MANTISSA_LEN +: EXP_LEN]) && (a[MANTISSA_LEN-1:0] == '0);
    b_inf  = (&b[MANTISSA_LEN +: EXP_LEN]) && (b[MANTISSA_LEN-1:0] == '0);
    a_zero = (a[W-2:0] == '0);
    b_zero = (b[W-2:0] == '0);
    nan    = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    inf    = !nan && (a_inf || b_inf);
    return {nan, inf, !nan && !inf && (a_zero || b_zero)};
  endfunction

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    float_point_multiplier #(.EXP_LEN(EXP_LEN), .MANTISSA_LEN(MANTISSA_LEN)) u_core (
      .a_i      (opa_q[g*W +: W]),
      .b_i      (opb_q[g*W +: W]),
      .product_o(core_prod[g*W +: W])
    );
  end

  assign inp_ready = !reset && (state_q == S_IDLE) && (count_q < DEPTH_C);
  assign accept    = inp_valid && inp_ready;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != S_IDLE) || (count_q != '0);
  assign {out_nan_flag, out_inf_flag, out_zero_flag, out_product} = out_valid ? mem_q[rd_q] : '0;

  always_comb begin
    nan_c  = '0;
    inf_c  = '0;
    zero_c = '0;
    for (int i = 0; i < NUM_LANES; i++)
      {nan_c[i], inf_c[i], zero_c[i]} = classify(inp_a[i*W +: W], inp_b[i*W +: W]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    nan_d   = nan_q;
    inf_d   = inf_q;
    zero_d  = zero_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        opa_d   = inp_a;
        opb_d   = inp_b;
        nan_d   = nan_c;
        inf_d   = inf_c;
        zero_d  = zero_c;
        cnt_d   = CW'(MULT_LATENCY - 1);
        state_d = S_COMPUTE;
      end
      S_COMPUTE: if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      nan_q   <= '0;
      inf_q   <= '0;
      zero_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      zero_q  <= zero_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the outputs mask it while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_q] <= {nan_q, inf_q, zero_q, core_prod};
  end
endmodule

// File: tb/tb_float_point_multiplier_stream.sv
// Self-checking bench for float_point_multiplier_stream: directed cases plus a randomized stream
// compared against an arithmetic reference model of single-precision multiplication.
module tb_float_point_multiplier_stream;
  localparam int NL = 2;
  localparam int W  = 32;

  typedef struct packed {
    logic [NL*W-1:0] p;
    logic [NL-1:0]   nan_f;
    logic [NL-1:0]   inf_f;
    logic [NL-1:0]   zero_f;
  } res_t;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            inp_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            inp_ready, out_valid, busy;
  logic [NL*W-1:0] inp_a = '0, inp_b = '0, out_product;
  logic [NL-1:0]   out_nan_flag, out_inf_flag, out_zero_flag;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];

  always #5 clock = ~clock;

  float_point_multiplier_stream #(
    .EXP_LEN(8), .MANTISSA_LEN(23), .NUM_LANES(NL), .MULT_LATENCY(4), .RESULT_DEPTH(2)
  ) dut (
    .clock(clock), .reset(reset), .inp_valid(inp_valid), .inp_ready(inp_ready),
    .inp_a(inp_a), .inp_b(inp_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_nan_flag(out_nan_flag), .out_inf_flag(out_inf_flag),
    .out_zero_flag(out_zero_flag), .busy(busy)
  );

  // Exact significand product, rounded to 24 significant bits by repeated halving (ties to even).
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh, be;
    longint unsigned sa, sb, sig, keep, rem, half;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0) && (a[22:0] == 0);
    b_zero = (eb == 0) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {s, 31'h0};
    sa = 64'h800000 + 64'(a[22:0]);
    sb = 64'h800000 + 64'(b[22:0]);
    sig = sa * sb;
    e = ea + eb - 254 - 46;
    sh = 0;
    while ((sig >> sh) >= 64'd16777216) sh++;
    keep = sig >> sh;
    rem  = sig - (keep << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep++;
    if (keep == 64'd16777216) begin
      keep = keep >> 1;
      sh++;
    end
    be = e + sh + 23 + 127;
    if (be >= 255) return {s, 8'hFF, 23'h0};
    if (be <= 0) return {s, 31'h0};
    return {s, be[7:0], keep[22:0]};
  endfunction

  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    logic an, bn, ai, bi, az, bz, nan, inf;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:0] == 0);
    bz = (b[30:0] == 0);
    nan = an || bn || (ai && bz) || (bi && az);
    inf = !nan && (ai || bi);
    return {nan, inf, !nan && !inf && (az || bz)};
  endfunction

  function automatic res_t model(input logic [NL*W-1:0] a, input logic [NL*W-1:0] b);
    res_t r;
    logic [2:0] f;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      r.p[i*W +: W] = ref_mul(a[i*W +: W], b[i*W +: W]);
      f = ref_flags(a[i*W +: W], b[i*W +: W]);
      r.nan_f[i]  = f[2];
      r.inf_f[i]  = f[1];
      r.zero_f[i] = f[0];
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] sp [6];
    int s, e, m;
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h3F800000};
    if ($urandom_range(0, 7) == 0) return sp[$urandom_range(0, 5)];
    s = $urandom_range(0, 1);
    e = $urandom_range(64, 190);
    m = $urandom;
    return {s[0], e[7:0], m[22:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input res_t e);
    check({tag, ".prod"}, out_product, e.p);
    check({tag, ".nan"},  out_nan_flag, e.nan_f);
    check({tag, ".inf"},  out_inf_flag, e.inf_f);
    check({tag, ".zero"}, out_zero_flag, e.zero_f);
  endtask

  // Offers a bundle until it is accepted; returns just after the handshake edge.
  task automatic handshake(input string tag, input logic [NL*W-1:0] a, input logic [NL*W-1:0] b);
    int t;
    t = 0;
    inp_a = a;
    inp_b = b;
    inp_valid = 1'b1;
    while (!inp_ready && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    check({tag, ".accept"}, inp_ready, 1'b1);
    @(posedge clock); #1;
    inp_valid = 1'b0;
    exp_q.push_back(model(a, b));
  endtask

  task automatic pop_check(input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      @(posedge clock); #1;
      t++;
    end
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".pending"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) check_head(tag, exp_q.pop_front());
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] sa [3], sb [3];
    logic [2:0]  sf [3];
    logic [NL*W-1:0] b1a, b1b, b2a, b2b, b3a, b3b, ca, cb;
    res_t e;
    int sent, got, cyc, last_pop, seen;
    logic hs, pp;

    repeat (2) @(posedge clock);
    #1;
    check("rst.inp_ready", inp_ready, 1'b0);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.product", out_product, '0);
    check("rst.flags", {out_nan_flag, out_inf_flag, out_zero_flag}, '0);
    reset = 1'b0;
    #1;
    check("post_rst.inp_ready", inp_ready, 1'b1);

    // 2.0 x 3.0 in lane 0, 1.0 x 1.0 in lane 1; result appears exactly four edges after the handshake.
    handshake("lat", {32'h3F800000, 32'h40000000}, {32'h3F800000, 32'h40400000});
    for (int j = 1; j <= 4; j++) begin
      @(posedge clock); #1;
      check($sformatf("lat.valid_edge%0d", j), out_valid, j == 4);
    end
    check("lat.const_prod", out_product, {32'h3F800000, 32'h40C00000});
    check("lat.const_flags", {out_nan_flag, out_inf_flag, out_zero_flag}, '0);
    pop_check("lat");
    check("lat.empty_valid", out_valid, 1'b0);
    check("lat.empty_prod", out_product, '0);
    check("lat.idle_busy", busy, 1'b0);

    handshake("two", {32'h80000000, 32'h3FC00000}, {32'h40000000, 32'h3FC00000});
    repeat (4) @(posedge clock);
    #1;
    check("two.const_prod", out_product, {32'h80000000, 32'h40100000});
    check("two.const_zero", out_zero_flag, 2'b10);
    pop_check("two");

    sa = '{32'h7F800000, 32'h7FC00000, 32'hFF800000};
    sb = '{32'h00000000, 32'h3F800000, 32'h40000000};
    sf = '{3'b100, 3'b100, 3'b010};
    for (int k = 0; k < 3; k++) begin
      handshake($sformatf("spc%0d", k), {32'h3F800000, sa[k]}, {32'h3F800000, sb[k]});
      repeat (4) @(posedge clock);
      #1;
      check($sformatf("spc%0d.const_flags", k), {out_nan_flag[0], out_inf_flag[0], out_zero_flag[0]}, sf[k]);
      pop_check($sformatf("spc%0d", k));
    end

    // Backpressure: two bundles fill the FIFO, a third must wait for a pop.
    b1a = {rand_op(), rand_op()}; b1b = {rand_op(), rand_op()};
    b2a = {rand_op(), rand_op()}; b2b = {rand_op(), rand_op()};
    b3a = {rand_op(), rand_op()}; b3b = {rand_op(), rand_op()};
    handshake("bp1", b1a, b1b);
    handshake("bp2", b2a, b2b);
    inp_a = b3a;
    inp_b = b3b;
    inp_valid = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    check("bp.full_ready", inp_ready, 1'b0);
    check("bp.full_busy", busy, 1'b1);
    check_head("bp.head1", exp_q[0]);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    e = exp_q.pop_front();
    check_head("bp.head2", exp_q[0]);
    check("bp.ready_again", inp_ready, 1'b1);
    @(posedge clock); #1;
    inp_valid = 1'b0;
    exp_q.push_back(model(b3a, b3b));
    pop_check("bp.drain2");
    pop_check("bp.drain3");
    repeat (8) @(posedge clock);
    #1;
    check("bp.no_dup", out_valid, 1'b0);

    // Continuous push/pop with randomized operands.
    out_ready = 1'b1;
    ca = {rand_op(), rand_op()};
    cb = {rand_op(), rand_op()};
    inp_a = ca;
    inp_b = cb;
    inp_valid = 1'b1;
    sent = 0; got = 0; cyc = 0; last_pop = -1;
    while (got < 12 && cyc < 400) begin
      @(negedge clock);
      hs = inp_valid && inp_ready;
      pp = out_valid && out_ready;
      if (sent > 0) check("thru.busy", busy, 1'b1);
      if (pp) begin
        check("thru.pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check_head("thru", exp_q.pop_front());
        if (last_pop >= 0) check("thru.interval", cyc - last_pop, 5);
        last_pop = cyc;
        got++;
      end
      @(posedge clock); #1;
      cyc++;
      if (hs) begin
        exp_q.push_back(model(ca, cb));
        sent++;
        if (sent < 12) begin
          ca = {rand_op(), rand_op()};
          cb = {rand_op(), rand_op()};
          inp_a = ca;
          inp_b = cb;
        end else inp_valid = 1'b0;
      end
    end
    check("thru.count", got, 12);
    out_ready = 1'b0;
    inp_valid = 1'b0;

    // Reset with one result queued and a second bundle at counter == 2.
    exp_q.delete();
    handshake("rmo1", {rand_op(), rand_op()}, {rand_op(), rand_op()});
    handshake("rmo2", {rand_op(), rand_op()}, {rand_op(), rand_op()});
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("rmo.valid", out_valid, 1'b0);
    check("rmo.busy", busy, 1'b0);
    check("rmo.prod", out_product, '0);
    reset = 1'b0;
    #1;
    check("rmo.ready", inp_ready, 1'b1);
    exp_q.delete();
    seen = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (out_valid) seen++;
    end
    check("rmo.no_stale", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
